// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates per dispatch, captures CDB results,
// retires in program order one entry per cycle into the register file.
module reorder_buffer #(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = 3,
  parameter int AREG_W = 5,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc_valid,
  input  logic              alloc_has_dest,
  input  logic [AREG_W-1:0] alloc_dest,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              flush,
  output logic              commit_valid,
  output logic              commit_en,
  output logic [AREG_W-1:0] commit_reg,
  output logic [DATA_W-1:0] commit_data,
  output logic [TAG_W:0]    count,
  output logic              empty
);

  localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W:0] PTR_ONE  = (TAG_W+1)'(1);

  logic [DEPTH-1:0]  valid;
  logic [DEPTH-1:0]  done;
  logic [DEPTH-1:0]  has_dest;
  logic [AREG_W-1:0] dest [DEPTH];
  logic [DATA_W-1:0] data [DEPTH];
  logic [TAG_W:0]    head;
  logic [TAG_W:0]    tail;

  logic [TAG_W-1:0] head_idx;
  logic [TAG_W-1:0] tail_idx;
  logic             retire;
  logic             alloc_fire;
  logic             cdb_hit;
  logic             wr_reg;

  assign head_idx    = head[TAG_W-1:0];
  assign tail_idx    = tail[TAG_W-1:0];
  assign count       = tail - head;
  assign empty       = (count == '0);
  assign alloc_ready = (count != FULL_CNT);
  assign alloc_tag   = tail_idx;

  assign retire     = valid[head_idx] & done[head_idx];
  assign alloc_fire = alloc_valid & alloc_ready;
  assign cdb_hit    = cdb_valid & valid[cdb_tag];
  assign wr_reg     = retire & has_dest[head_idx];

  // Control state; an allocating tail entry is invalid pre-edge so
  // a same-cycle CDB tag on it never hits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid        <= '0;
      done         <= '0;
      has_dest     <= '0;
      head         <= '0;
      tail         <= '0;
      commit_valid <= 1'b0;
      commit_en    <= 1'b0;
      commit_reg   <= '0;
      commit_data  <= '0;
    end else if (flush) begin
      valid        <= '0;
      done         <= '0;
      head         <= '0;
      tail         <= '0;
      commit_valid <= 1'b0;
      commit_en    <= 1'b0;
      commit_reg   <= '0;
      commit_data  <= '0;
    end else begin
      if (cdb_hit)
        done[cdb_tag] <= 1'b1;
      if (alloc_fire) begin
        valid[tail_idx]    <= 1'b1;
        done[tail_idx]     <= 1'b0;
        has_dest[tail_idx] <= alloc_has_dest;
        tail               <= tail + PTR_ONE;
      end
      if (retire) begin
        valid[head_idx] <= 1'b0;
        head            <= head + PTR_ONE;
      end
      commit_valid <= retire;
      commit_en    <= wr_reg;
      // Gate index/data so the register file bit enables stay quiet.
      commit_reg   <= wr_reg ? dest[head_idx] : '0;
      commit_data  <= wr_reg ? data[head_idx] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!flush) begin
      if (alloc_fire) begin
        dest[tail_idx] <= alloc_dest;
        data[tail_idx] <= '0;
      end
      if (cdb_hit)
        data[cdb_tag] <= cdb_data;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed plus random checks of reorder_buffer against an
// in-order queue model of the instruction window.
module tb_reorder_buffer;

  localparam int DEPTH  = 8;
  localparam int TAG_W  = 3;
  localparam int AREG_W = 5;
  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic              alloc_valid;
  logic              alloc_has_dest;
  logic [AREG_W-1:0] alloc_dest;
  logic              alloc_ready;
  logic [TAG_W-1:0]  alloc_tag;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              flush;
  logic              commit_valid;
  logic              commit_en;
  logic [AREG_W-1:0] commit_reg;
  logic [DATA_W-1:0] commit_data;
  logic [TAG_W:0]    count;
  logic              empty;

  reorder_buffer #(
    .DEPTH(DEPTH), .TAG_W(TAG_W),
    .AREG_W(AREG_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid),
    .alloc_has_dest(alloc_has_dest),
    .alloc_dest(alloc_dest),
    .alloc_ready(alloc_ready),
    .alloc_tag(alloc_tag),
    .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag),
    .cdb_data(cdb_data),
    .flush(flush),
    .commit_valid(commit_valid),
    .commit_en(commit_en),
    .commit_reg(commit_reg),
    .commit_data(commit_data),
    .count(count),
    .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    bit          hd;
    logic [4:0]  dst;
    bit          dn;
    logic [63:0] val;
  } ent_t;

  ent_t q[$];
  int   tail_seq = 0;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    tail_seq = 0;
  endtask

  // One clock: drive, check pre-edge state, advance model, check commit.
  task automatic step(input bit av, input bit hd,
                      input logic [4:0] dst,
                      input bit cv, input int ctag,
                      input logic [63:0] cdat,
                      input bit fl);
    bit          ret;
    bit          rdy;
    bit          e_cv;
    bit          e_en;
    logic [4:0]  e_reg;
    logic [63:0] e_dat;
    ent_t        n;
    alloc_valid    = av;
    alloc_has_dest = hd;
    alloc_dest     = dst;
    cdb_valid      = cv;
    cdb_tag        = 3'(ctag);
    cdb_data       = cdat;
    flush          = fl;
    chk("count", 64'(count), 64'(q.size()));
    chk("empty", 64'(empty), 64'(q.size() == 0));
    chk("alloc_ready", 64'(alloc_ready), 64'(q.size() < DEPTH));
    chk("alloc_tag", 64'(alloc_tag), 64'(tail_seq));
    e_cv = 0; e_en = 0; e_reg = '0; e_dat = '0;
    @(posedge clk);
    if (fl) begin
      model_reset();
    end else begin
      rdy = q.size() < DEPTH;
      ret = q.size() > 0 && q[0].dn;
      if (ret) begin
        e_cv = 1;
        e_en = q[0].hd;
        if (q[0].hd) begin
          e_reg = q[0].dst;
          e_dat = q[0].val;
        end
      end
      if (cv)
        foreach (q[i])
          if (q[i].tag == ctag) begin
            q[i].dn  = 1;
            q[i].val = cdat;
          end
      if (ret) void'(q.pop_front());
      if (av && rdy) begin
        n.tag = tail_seq; n.hd = hd; n.dst = dst;
        n.dn = 0; n.val = '0;
        q.push_back(n);
        tail_seq = (tail_seq + 1) % DEPTH;
      end
    end
    #1;
    chk("commit_valid", 64'(commit_valid), 64'(e_cv));
    chk("commit_en", 64'(commit_en), 64'(e_en));
    chk("commit_reg", 64'(commit_reg), 64'(e_reg));
    chk("commit_data", commit_data, e_dat);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic alloc(input bit hd, input logic [4:0] dst);
    step(1, hd, dst, 0, 0, 0, 0);
  endtask

  task automatic cdb(input int t, input logic [63:0] d);
    step(0, 0, 0, 1, t, d, 0);
  endtask

  initial begin
    alloc_valid = 0; alloc_has_dest = 0; alloc_dest = '0;
    cdb_valid = 0; cdb_tag = '0; cdb_data = '0; flush = 0;
    reset = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 64'(count), 0);
    chk("rst_empty", 64'(empty), 1);
    chk("rst_ready", 64'(alloc_ready), 1);
    chk("rst_commit_en", 64'(commit_en), 0);
    reset = 1;

    // In-order completion of three entries.
    alloc(1, 1); alloc(1, 2); alloc(1, 3);
    cdb(0, 64'hA); cdb(1, 64'hB); cdb(2, 64'hC);
    idle(3);
    chk("t1_empty", 64'(empty), 1);

    // Out-of-order completion holds retirement behind the head.
    step(0, 0, 0, 0, 0, 0, 1);
    alloc(1, 4); alloc(1, 5);
    cdb(1, 64'h55); idle(1);
    cdb(0, 64'h44); idle(4);

    // Fill, refuse the ninth, drain, refill across the wrap.
    step(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 9; i++) alloc(1, 5'(i + 8));
    chk("fill_count", 64'(count), 8);
    for (int i = 0; i < 8; i++) cdb(i, {$urandom, $urandom});
    idle(3);
    for (int i = 0; i < 8; i++) alloc(1, 5'(i + 16));
    for (int i = 7; i >= 0; i--) cdb(i, {$urandom, $urandom});
    idle(10);

    // Entry without a destination retires with gated outputs.
    alloc(0, 5'd9);
    cdb(tail_seq == 0 ? 7 : tail_seq - 1, 64'hDEAD_BEEF);
    idle(3);

    // Flush with five entries, two of them complete.
    for (int i = 0; i < 5; i++) alloc(1, 5'(i + 1));
    cdb((tail_seq + 5) % DEPTH, 64'h11);
    cdb((tail_seq + 6) % DEPTH, 64'h22);
    step(0, 0, 0, 0, 0, 0, 1);
    idle(1);
    alloc(1, 5'd30);
    idle(2);

    // Asynchronous reset between edges.
    alloc(1, 1); alloc(1, 2);
    cdb(0, 64'h77);
    #2 reset = 0;
    #1;
    chk("arst_count", 64'(count), 0);
    chk("arst_commit_en", 64'(commit_en), 0);
    chk("arst_ready", 64'(alloc_ready), 1);
    chk("arst_tag", 64'(alloc_tag), 0);
    model_reset();
    @(posedge clk);
    #1 reset = 1;
    alloc(1, 3);
    idle(1);

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      int t;
      if (q.size() > 0 && $urandom_range(3) != 0)
        t = q[$urandom_range(q.size() - 1)].tag;
      else
        t = $urandom_range(DEPTH - 1);
      step($urandom_range(9) < 6, $urandom_range(3) != 0,
           5'($urandom), $urandom_range(1) == 1, t,
           {$urandom, $urandom}, $urandom_range(49) == 0);
    end
    idle(12);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Circular reorder buffer for the out-of-order core. Allocates an entry per dispatched instruction and captures results from the common data bus (CDB). Retires completed entries strictly in program order, at most one per cycle. Its registered commit outputs directly drive the per-bit write enables and data inputs of the architectural register file's enable-flop array.

## Interface
Parameters:
- DEPTH, 8, number of entries; power of two, at least 2
- TAG_W, 3, log2(DEPTH); entry index / tag width
- AREG_W, 5, architectural register index width
- DATA_W, 64, result data width

Ports:
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  asynchronous, active-low; clears all state immediately when low
- alloc_valid  in  1  dispatch requests an entry this cycle
- alloc_has_dest  in  1  instruction writes a register
- alloc_dest  in  AREG_W  destination architectural register
- alloc_ready  out  1  entry available; combinational from registered count
- alloc_tag  out  TAG_W  tag the entry gets if allocated this cycle (tail index); combinational
- cdb_valid  in  1  result broadcast valid
- cdb_tag  in  TAG_W  tag of the completing entry
- cdb_data  in  DATA_W  result value
- flush  in  1  synchronous squash of all entries
- commit_valid  out  1  an entry retired (registered)
- commit_en  out  1  register file write enable (registered)
- commit_reg  out  AREG_W  register file write index (registered)
- commit_data  out  DATA_W  register file write data (registered)
- count  out  TAG_W+1  occupied entries, 0..DEPTH
- empty  out  1  count == 0

## Operation
- Per-entry state: valid, done, has_dest, dest, data.
- Pointers: head and tail are TAG_W+1 bits wide. The low bits index the entry and the MSB is a wrap bit. Both increment modulo 2*DEPTH.
- count = tail - head, computed modulo 2^(TAG_W+1). Full when count == DEPTH. alloc_ready = !full.
- **Allocate** when alloc_valid && alloc_ready:
  - entry[tail] gets valid=1, done=0, has_dest/dest from the inputs, data=0.
  - tail increments.
  - alloc_valid while not ready is ignored; the bench must hold the request.
- **Complete** when cdb_valid && entry[cdb_tag].valid:
  - entry[cdb_tag] gets done=1 and data=cdb_data.
  - A CDB hit on an invalid entry is ignored.
  - A CDB hit on an already-done entry overwrites data.
- **Retire** when entry[head].valid && entry[head].done at the current edge:
  - head entry valid clears and head increments.
  - Next-cycle outputs: commit_valid=1, commit_en=has_dest, commit_reg=dest, commit_data=data.
- When nothing retires, the next cycle drives commit_valid=0, commit_en=0, commit_reg=0, commit_data=0.
- **Simultaneous events in one cycle:**
  - Allocate and retire may both occur; count is unchanged.
  - alloc_ready reflects pre-edge state, so a full buffer refuses allocation even in a retiring cycle.
  - A CDB hit on the head entry does not retire it that same edge; it retires at the following edge.
  - A CDB tag equal to the entry being allocated in that cycle is ignored (the entry is still invalid).
- **Flush** (synchronous, highest priority):
  - All valid/done bits clear and head = tail = 0.
  - Commit outputs are 0 the next cycle.
  - Allocation, completion and retirement in the flush cycle are discarded.
- **Reset low** (any time, including mid-operation):
  - All entries invalid, pointers 0.
  - Outputs: commit_* = 0, alloc_ready=1, alloc_tag=0, count=0, empty=1.
  - Takes effect without a clock edge. Normal operation resumes on the first posedge after reset returns high.

## Timing
- Allocation: an entry accepted at edge N is visible in count after edge N.
- Completion to commit: CDB at edge N marks done. If that entry is head, retire is decided at edge N+1 and commit_* are asserted during cycle N+1 to N+2. The minimum CDB-to-commit_en latency is therefore 2 edges.
- Throughput: one allocation, one completion and one retire per cycle.
- Commit outputs are pulses, held for exactly one cycle per retired entry.
- Wrap-around: after DEPTH allocations, tail low bits return to 0 with the wrap bit toggled. Full/empty are distinguished by the wrap bit alone.

## Test plan
- Reset then allocate 3 (dest 1,2,3, has_dest=1). CDB tags 0,1,2 with 0xA,0xB,0xC on consecutive cycles. Required: commit_en pulses on three consecutive cycles with reg 1/0xA, 2/0xB, 3/0xC; count returns to 0 and empty=1.
- Out-of-order completion: allocate tags 0,1; CDB tag 1 first, then tag 0 two cycles later. Required: no commit until tag 0 completes, then commits 0 and 1 on back-to-back cycles in order.
- Fill: allocate 8 entries. Required: count=8, alloc_ready=0, a 9th request is ignored. Then complete and retire all 8 and allocate 8 more. Required: alloc_tag wraps 7 to 0 and commit order is preserved across the wrap.
- Entry with has_dest=0 completes. Required: commit_valid=1, commit_en=0, commit_reg=0, commit_data=0.
- Flush with 5 entries, 2 of them done. Required: next cycle count=0, empty=1, no commit pulse; the next allocation gets tag 0.
- Assert reset low mid-stream between clock edges. Required: outputs go immediately to count=0, commit_en=0, alloc_ready=1, alloc_tag=0. The first allocation after release gets tag 0.
